// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction, write-back control and retire counter
//
// Purpose:
//   Registers the MEM-stage entry one cycle after data memory. Load data is
//   extracted (byte/half/word, little-endian lane from alu_res[1:0]) and
//   sign/zero-extended before capture, so the register-file write port is
//   driven straight from registered state.
//
// Optional feature macro: WB_BYPASS_EN (adds byp_en/byp_addr/byp_data).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall, flush       hold stage / kill entry being captured (flush wins)
//   in_valid           MEM-stage entry valid
//   alu_res            ALU result, also the load byte address
//   mem_data           raw word read from data memory
//   mem_to_reg         1: write loaded data, 0: write alu_res
//   reg_write          instruction writes a register
//   rd                 destination register
//   load_size          00 byte, 01 half, 10 word, 11 treated as word
//   load_unsigned      1: zero-extend, 0: sign-extend
//   wb_valid           registered entry valid
//   wb_en              register-file write enable
//   wb_addr, wb_data   register-file write address / data
//   misalign           registered misaligned-load flag
//   retire_cnt         count of accepted valid entries (wraps)
//   byp_en/addr/data   forwarding copy of the write port (WB_BYPASS_EN only)

module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_to_reg,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [1:0]            load_size,
    input  logic                  load_unsigned,
    output logic                  wb_valid,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  misalign,
    output logic [CNT_W-1:0]      retire_cnt
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_en,
    output logic [REG_ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  misalign_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_W-1:0]     data_d;
    logic                  misalign_d;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_W-1:0]     load_val;
    logic                  bad_align;

    always_comb begin
        byte_lane  = 8'h00;
        half_lane  = 16'h0000;
        load_val   = '0;
        bad_align  = 1'b0;
        data_d     = '0;
        misalign_d = 1'b0;

        case (alu_res[1:0])
            2'd0:    byte_lane = mem_data[7:0];
            2'd1:    byte_lane = mem_data[15:8];
            2'd2:    byte_lane = mem_data[23:16];
            default: byte_lane = mem_data[31:24];
        endcase
        half_lane = alu_res[1] ? mem_data[31:16] : mem_data[15:0];

        case (load_size)
            2'b00: begin
                load_val = load_unsigned ? {{(DATA_W-8){1'b0}}, byte_lane}
                                         : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            end
            2'b01: begin
                load_val  = load_unsigned ? {{(DATA_W-16){1'b0}}, half_lane}
                                          : {{(DATA_W-16){half_lane[15]}}, half_lane};
                bad_align = alu_res[0];
            end
            default: begin
                // 11 is reserved and behaves exactly like a word load
                load_val  = mem_data;
                bad_align = (alu_res[1:0] != 2'b00);
            end
        endcase

        if (mem_to_reg) begin
            // Misalignment only matters for a live load; a bubble keeps
            // whatever was extracted since it can never be written back.
            if (in_valid && bad_align) begin
                misalign_d = 1'b1;
                data_d     = '0;
            end else begin
                data_d = load_val;
            end
        end else begin
            data_d = alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            misalign_q  <= 1'b0;
            cnt_q       <= '0;
        end else if (flush) begin
            // Only the flags are cleared; payload holds and is never used.
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            reg_write_q <= reg_write;
            addr_q      <= rd;
            data_q      <= data_d;
            misalign_q  <= misalign_d;
            if (in_valid) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign wb_valid   = valid_q;
    assign wb_addr    = addr_q;
    assign wb_data    = data_q;
    assign misalign   = misalign_q;
    assign retire_cnt = cnt_q;
    // r0 is hardwired zero, so it is never written
    assign wb_en      = valid_q & reg_write_q & (addr_q != '0) & ~misalign_q;

`ifdef WB_BYPASS_EN
    assign byp_en   = wb_en & ~stall;
    assign byp_addr = addr_q;
    assign byp_data = data_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage

module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  load_size;
    logic        load_unsigned;

    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        misalign;
    logic [31:0] retire_cnt;

    logic        wb_valid4;
    logic        wb_en4;
    logic [4:0]  wb_addr4;
    logic [31:0] wb_data4;
    logic        misalign4;
    logic [3:0]  retire_cnt4;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .alu_res(alu_res), .mem_data(mem_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd),
        .load_size(load_size), .load_unsigned(load_unsigned),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .misalign(misalign), .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .alu_res(alu_res), .mem_data(mem_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd),
        .load_size(load_size), .load_unsigned(load_unsigned),
        .wb_valid(wb_valid4), .wb_en(wb_en4), .wb_addr(wb_addr4),
        .wb_data(wb_data4), .misalign(misalign4), .retire_cnt(retire_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: what the write-back stage should be holding
    bit          m_valid;
    bit          m_rw;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          m_mis;
    longint      m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic bit [31:0] ref_load(input bit [31:0] addr, input bit [31:0] word,
                                           input bit [1:0] size, input bit uns);
        int unsigned a = addr % 4;
        longint unsigned v;
        if (size == 0) begin
            v = (longint'(word) / (longint'(1) << (8 * a))) % 256;
            if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (size == 1) begin
            v = (longint'(word) / (longint'(1) << (16 * (a / 2)))) % 65536;
            if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = word;
        end
        return v[31:0];
    endfunction

    function automatic bit ref_misaligned(input bit [31:0] addr, input bit [1:0] size);
        int unsigned a = addr % 4;
        if (size == 1) return (a % 2) != 0;
        if (size >= 2) return a != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_addr = 0; m_data = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 0;
            m_mis   = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_rw    = reg_write;
            m_addr  = rd;
            if (!mem_to_reg) begin
                m_data = alu_res;
                m_mis  = 0;
            end else if (in_valid && ref_misaligned(alu_res, load_size)) begin
                m_data = 0;
                m_mis  = 1;
            end else begin
                m_data = ref_load(alu_res, mem_data, load_size, load_unsigned);
                m_mis  = 0;
            end
            if (in_valid) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit exp_en = m_valid && m_rw && (m_addr != 0) && !m_mis;
        chk({tag, ".wb_valid"},   32'(wb_valid), 32'(m_valid));
        chk({tag, ".wb_en"},      32'(wb_en), 32'(exp_en));
        chk({tag, ".wb_addr"},    32'(wb_addr), 32'(m_addr));
        chk({tag, ".wb_data"},    wb_data, m_data);
        chk({tag, ".misalign"},   32'(misalign), 32'(m_mis));
        chk({tag, ".retire_cnt"}, retire_cnt, m_cnt[31:0]);
        chk({tag, ".retire_cnt4"}, 32'(retire_cnt4), 32'(m_cnt % 16));
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] m,
                         input logic m2r, input logic rw, input logic [4:0] r,
                         input logic [1:0] sz, input logic u);
        in_valid = v; alu_res = a; mem_data = m; mem_to_reg = m2r;
        reg_write = rw; rd = r; load_size = sz; load_unsigned = u;
    endtask

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_en;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] snap_data;
        logic [31:0] snap_cnt;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        vecs.push_back('{"lb_signed",   32'h103, 32'h80FF_1234, 1, 1, 5,  2'b00, 0, 32'hFFFF_FF80, 0, 1});
        vecs.push_back('{"lhu",         32'h102, 32'h8001_7FFF, 1, 1, 6,  2'b01, 1, 32'h0000_8001, 0, 1});
        vecs.push_back('{"lh_signed",   32'h102, 32'h8001_7FFF, 1, 1, 6,  2'b01, 0, 32'hFFFF_8001, 0, 1});
        vecs.push_back('{"lh_lo",       32'h100, 32'h8001_7FFF, 1, 1, 7,  2'b01, 0, 32'h0000_7FFF, 0, 1});
        vecs.push_back('{"lbu_lane0",   32'h100, 32'h80FF_1234, 1, 1, 8,  2'b00, 1, 32'h0000_0034, 0, 1});
        vecs.push_back('{"lb_lane2",    32'h102, 32'h80FF_1234, 1, 1, 9,  2'b00, 0, 32'hFFFF_FFFF, 0, 1});
        vecs.push_back('{"lw_misalign", 32'h101, 32'h80FF_1234, 1, 1, 10, 2'b10, 0, 32'h0000_0000, 1, 0});
        vecs.push_back('{"lh_misalign", 32'h103, 32'h80FF_1234, 1, 1, 11, 2'b01, 1, 32'h0000_0000, 1, 0});
        vecs.push_back('{"size11_word", 32'h104, 32'h80FF_1234, 1, 1, 12, 2'b11, 0, 32'h80FF_1234, 0, 1});
        vecs.push_back('{"alu_unalign", 32'h101, 32'hDEAD_BEEF, 0, 1, 13, 2'b10, 0, 32'h0000_0101, 0, 1});
        vecs.push_back('{"alu_rd0",     32'h1234, 32'h0,        0, 1, 0,  2'b10, 0, 32'h0000_1234, 0, 0});
        vecs.push_back('{"no_regwrite", 32'h55AA, 32'h0,        0, 0, 14, 2'b00, 0, 32'h0000_55AA, 0, 0});

        foreach (vecs[i]) begin
            drive(1, vecs[i].alu, vecs[i].mem, vecs[i].m2r, vecs[i].rw, vecs[i].rd,
                  vecs[i].sz, vecs[i].uns);
            step();
            chk({vecs[i].name, ".data"}, wb_data, vecs[i].exp_data);
            chk({vecs[i].name, ".mis"},  32'(misalign), 32'(vecs[i].exp_mis));
            chk({vecs[i].name, ".en"},   32'(wb_en), 32'(vecs[i].exp_en));
            chk({vecs[i].name, ".addr"}, 32'(wb_addr), 32'(vecs[i].rd));
            chk({vecs[i].name, ".valid"}, 32'(wb_valid), 32'd1);
        end
        chk("table.retire_cnt", retire_cnt, 32'(vecs.size()));

        // Stall 3 cycles with changing inputs: everything holds
        drive(1, 32'h200, 32'h1111_2222, 1, 1, 3, 2'b10, 0);
        step();
        snap_data = wb_data;
        snap_cnt  = retire_cnt;
        chk("pre_stall.data", wb_data, 32'h1111_2222);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h300 + k, 32'h9999_0000 + k, k[0], 1, 5'(20 + k), 2'(k), 1);
            step();
            chk("stall.data", wb_data, snap_data);
            chk("stall.addr", 32'(wb_addr), 32'd3);
            chk("stall.cnt",  retire_cnt, snap_cnt);
            chk("stall.valid", 32'(wb_valid), 32'd1);
        end

        // Stall and flush on the same edge: flush wins, count holds
        flush = 1'b1;
        step();
        chk("stall_flush.valid", 32'(wb_valid), 32'd0);
        chk("stall_flush.en",    32'(wb_en), 32'd0);
        chk("stall_flush.cnt",   retire_cnt, snap_cnt);
        stall = 1'b0;

        // Flush over a misaligned load clears misalign too
        flush = 1'b0;
        drive(1, 32'h101, 32'h0, 1, 1, 4, 2'b10, 0);
        step();
        chk("mis_before_flush", 32'(misalign), 32'd1);
        flush = 1'b1;
        step();
        chk("flush.misalign", 32'(misalign), 32'd0);
        chk("flush.valid", 32'(wb_valid), 32'd0);
        flush = 1'b0;
        check_model("post_flush");

        // Async reset mid-stall: clears immediately, between edges
        stall = 1'b1;
        drive(1, 32'h400, 32'h0, 0, 1, 9, 0, 0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        #3;
        rst_n = 1'b1;
        stall = 1'b0;

        // Counter wrap on the 4-bit instance: 15 accepts, then one more
        for (int k = 0; k < 15; k++) begin
            drive(1, 32'(k * 4), 32'h0, 0, 1, 1, 0, 0);
            step();
        end
        chk("wrap.cnt4_allones", 32'(retire_cnt4), 32'd15);
        drive(1, 32'h1234, 32'h0, 0, 1, 0, 0, 0);
        step();
        chk("wrap.cnt4_zero", 32'(retire_cnt4), 32'd0);
        chk("wrap.cnt32", retire_cnt, 32'd16);
        chk("wrap.rd0_valid", 32'(wb_valid), 32'd1);
        chk("wrap.rd0_en", 32'(wb_en), 32'd0);

        // Randomized stimulus against the reference model
        for (int k = 0; k < 400; k++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), $urandom_range(0, 1));
            step();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
